// File: rtl/timebase_gen.sv
// Multi-channel programmable clock-enable and square-wave generator.
// Each channel divides clk_100MHz by a writable half-period.
module timebase_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 25000000,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_out,
  output logic              cfg_ack
);

  logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] lim;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            sq_q, sq_d;
  logic [NUM_CH-1:0]            wr;
  logic                         ack_q, ack_d;
  logic                         acc;

  // Next state: sync beats a write, a write beats disable,
  // disable beats normal counting. A zero divisor acts as one.
  always_comb begin
    acc    = cfg_we && (int'(cfg_ch) < NUM_CH);
    ack_d  = acc;
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = '0;
    sq_d   = sq_q;
    wr     = '0;
    lim    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lim[i] = (div_q[i] == '0) ? '0
             : div_q[i] - CNT_W'(1);
      wr[i]  = acc && (int'(cfg_ch) == i);
      if (wr[i]) begin
        div_d[i] = cfg_div;
      end
      if (sync) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (wr[i]) begin
        cnt_d[i] = '0;
      end else if (!ch_en[i]) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (cnt_q[i] == lim[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        sq_d[i]   = ~sq_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State registers; reset restores the default divisor everywhere.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= CNT_W'(DEF_DIV);
        cnt_q[i] <= '0;
      end
      tick_q <= '0;
      sq_q   <= '0;
      ack_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
      ack_q  <= ack_d;
    end
  end

  assign tick    = tick_q;
  assign sq_out  = sq_q;
  assign cfg_ack = ack_q;

endmodule

// File: tb/tb_timebase_gen.sv
// Directed bench for timebase_gen.
// Three channels, channel 2 kept disabled.
module tb_timebase_gen;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 4;
  localparam int CH_W    = 2;

  logic              clk_100MHz = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq_out;
  logic              cfg_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  timebase_gen #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DEF_DIV(DEF_DIV),
    .CH_W   (CH_W)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .ch_en     (ch_en),
    .sync      (sync),
    .tick      (tick),
    .sq_out    (sq_out),
    .cfg_ack   (cfg_ack)
  );

  typedef struct {
    logic       sy;
    logic       we;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [2:0] en;
    logic [2:0] t;
    logic [2:0] s;
    logic       a;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(
    input logic sy, input logic we,
    input logic [1:0] ch, input logic [7:0] dv,
    input logic [2:0] en, input logic [2:0] t,
    input logic [2:0] s, input logic a);
    vec_t r;
    r.sy = sy; r.we = we; r.ch = ch; r.dv = dv;
    r.en = en; r.t = t; r.s = s; r.a = a;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [2:0] act,
                     input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    ch_en   = 3'b011;
    sync    = 1'b0;

    // default divisor 4, both channels running
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b011,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b011,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b011,3'b011,0));
    // ch1 <- 3 mid-count
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b011,0));
    v.push_back(mk(0,1,1,3,3'b011,3'b000,3'b011,1));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b001,3'b010,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b010,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b011,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b010,3'b001,0));
    // ch0 <- 0 (acts as 1)
    v.push_back(mk(0,1,0,0,3'b011,3'b000,3'b001,1));
    v.push_back(mk(0,0,0,0,3'b011,3'b001,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b011,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b001,3'b010,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b001,3'b011,0));
    // back-to-back writes to ch0: 2 then 4
    v.push_back(mk(0,1,0,2,3'b011,3'b010,3'b001,1));
    v.push_back(mk(0,1,0,4,3'b011,3'b000,3'b001,1));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b001,0));
    // ch1 disabled for 5 cycles
    v.push_back(mk(0,0,0,0,3'b001,3'b000,3'b001,0));
    v.push_back(mk(0,0,0,0,3'b001,3'b000,3'b001,0));
    v.push_back(mk(0,0,0,0,3'b001,3'b001,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b001,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b001,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b001,3'b001,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b010,3'b011,0));
    // ch1 <- 5, then sync together with ch0 <- 3
    v.push_back(mk(0,1,1,5,3'b011,3'b000,3'b011,1));
    v.push_back(mk(1,1,0,3,3'b011,3'b000,3'b000,1));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b000,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b001,3'b001,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b001,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b010,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b001,3'b010,0));
    // write to nonexistent channel 3
    v.push_back(mk(0,1,3,7,3'b011,3'b000,3'b010,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b000,3'b010,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b001,3'b011,0));
    v.push_back(mk(0,0,0,0,3'b011,3'b010,3'b001,0));
    // leave ack high for the async reset check
    v.push_back(mk(0,1,0,2,3'b011,3'b000,3'b001,1));

    repeat (2) @(posedge clk_100MHz);
    #1;
    chk("rst_tick", tick, 3'b000);
    chk("rst_sq", sq_out, 3'b000);
    chk("rst_ack", {2'b00, cfg_ack}, 3'b000);
    reset = 1'b0;

    foreach (v[i]) begin
      sync    = v[i].sy;
      cfg_we  = v[i].we;
      cfg_ch  = v[i].ch;
      cfg_div = v[i].dv;
      ch_en   = v[i].en;
      @(posedge clk_100MHz);
      #1;
      chk($sformatf("tick e%0d", i + 1), tick, v[i].t);
      chk($sformatf("sq e%0d", i + 1), sq_out, v[i].s);
      chk($sformatf("ack e%0d", i + 1),
          {2'b00, cfg_ack}, {2'b00, v[i].a});
    end

    sync   = 1'b0;
    cfg_we = 1'b0;
    ch_en  = 3'b011;
    #2;
    reset = 1'b1;
    #1;
    chk("async_tick", tick, 3'b000);
    chk("async_sq", sq_out, 3'b000);
    chk("async_ack", {2'b00, cfg_ack}, 3'b000);
    @(posedge clk_100MHz);
    #1;
    chk("hold_sq", sq_out, 3'b000);
    #3;
    reset = 1'b0;

    // divisors back to 4 on both channels
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_100MHz);
      #1;
      chk($sformatf("post_tick k%0d", k), tick,
          (k % 4 == 0) ? 3'b011 : 3'b000);
      chk($sformatf("post_sq k%0d", k), sq_out,
          (k >= 4 && k < 8) ? 3'b011 : 3'b000);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
